// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared RAM port for mem_port_arbiter.
// The arbiter connects through the slave modport; requesters and RAM sit on the master side.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0;
    logic                  we0;
    logic                  lock0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic                  lock1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_dout,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_din, mem_we
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_dout,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one RAM port, with bounded lock bursts
// and a 1-cycle registered read-valid per requester.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_REQ0 = 2'd1,
        LK_REQ1 = 2'd2
    } lock_state_e;

    lock_state_e           lock_state_r;
    lock_state_e           lock_state_s;
    logic [2:0]            lock_cnt_r;
    logic [2:0]            lock_cnt_s;
    logic                  last_gnt_r;
    logic                  rvalid0_r;
    logic                  rvalid1_r;
    logic [ADDR_WIDTH-1:0] addr_hold_r;

    logic                  hold0_s;
    logic                  hold1_s;
    logic                  cap_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_din_s;
    logic                  mem_we_s;

    // Lock counter holds (locked grants - 1) and sticks at 7 once eight are reached.
    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        if (cnt == 3'd7) begin
            return 3'd7;
        end else begin
            return cnt + 3'd1;
        end
    endfunction

    // Grant selection: lock hold (breakable once capped), then round-robin.
    always_comb begin
        hold0_s = 1'b0;
        hold1_s = 1'b0;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        case (lock_state_r)
            LK_REQ0: hold0_s = bus.req0;
            LK_REQ1: hold1_s = bus.req1;
            default: begin
                hold0_s = 1'b0;
                hold1_s = 1'b0;
            end
        endcase
        cap_s = (lock_cnt_r == 3'd7);

        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (hold0_s) begin
            if (cap_s && bus.req1) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b1;
            end
        end else if (hold1_s) begin
            if (cap_s && bus.req0) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.req0 && bus.req1) begin
            if (last_gnt_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (bus.req0) begin
            gnt0_s = 1'b1;
        end else if (bus.req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next lock owner and hold count; any change of owner restarts the count.
    always_comb begin
        lock_state_s = LK_NONE;
        lock_cnt_s   = 3'd0;
        if (gnt0_s && bus.lock0) begin
            lock_state_s = LK_REQ0;
            if (lock_state_r == LK_REQ0) begin
                lock_cnt_s = sat_inc(lock_cnt_r);
            end else begin
                lock_cnt_s = 3'd0;
            end
        end else if (gnt1_s && bus.lock1) begin
            lock_state_s = LK_REQ1;
            if (lock_state_r == LK_REQ1) begin
                lock_cnt_s = sat_inc(lock_cnt_r);
            end else begin
                lock_cnt_s = 3'd0;
            end
        end else begin
            lock_state_s = LK_NONE;
            lock_cnt_s   = 3'd0;
        end
    end

    // RAM port drive; with no grant the last address is held and data is zeroed.
    always_comb begin
        mem_addr_s = addr_hold_r;
        mem_din_s  = {DATA_WIDTH{1'b0}};
        mem_we_s   = 1'b0;
        if (reset) begin
            mem_addr_s = {ADDR_WIDTH{1'b0}};
        end else if (gnt0_s) begin
            mem_addr_s = bus.addr0;
            mem_din_s  = bus.wdata0;
            mem_we_s   = bus.we0;
        end else if (gnt1_s) begin
            mem_addr_s = bus.addr1;
            mem_din_s  = bus.wdata1;
            mem_we_s   = bus.we1;
        end else begin
            mem_addr_s = addr_hold_r;
        end
    end

    // State registers: lock FSM, round-robin pointer, held address, read valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_r <= LK_NONE;
            lock_cnt_r   <= 3'd0;
            last_gnt_r   <= 1'b1;
            addr_hold_r  <= {ADDR_WIDTH{1'b0}};
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
        end else begin
            lock_state_r <= lock_state_s;
            lock_cnt_r   <= lock_cnt_s;
            addr_hold_r  <= mem_addr_s;
            rvalid0_r    <= gnt0_s & ~bus.we0;
            rvalid1_r    <= gnt1_s & ~bus.we1;
            if (gnt0_s) begin
                last_gnt_r <= 1'b0;
            end else if (gnt1_s) begin
                last_gnt_r <= 1'b1;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

    assign bus.gnt0     = gnt0_s;
    assign bus.gnt1     = gnt1_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_din  = mem_din_s;
    assign bus.mem_we   = mem_we_s;
    // Valids are masked while reset is high so a read accepted just before reset never surfaces.
    assign bus.rvalid0  = rvalid0_r & ~reset;
    assign bus.rvalid1  = rvalid1_r & ~reset;
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency RAM model on the shared port.
module tb_mem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: registered address, combinational read; unwritten words hold a fixed pattern.
    logic [AW-1:0] raddr_q = '0;
    bit            wv [0:1023];
    logic [DW-1:0] wm [0:1023];

    function automatic logic [DW-1:0] def_word(input logic [AW-1:0] a);
        if (a == 10'h005) return 16'h1234;
        return 16'hC000 | {6'b000000, a};
    endfunction

    always @(posedge clk) begin
        raddr_q <= bus.mem_addr;
        if (bus.mem_we === 1'b1) begin
            wm[bus.mem_addr] <= bus.mem_din;
            wv[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_dout = wv[raddr_q] ? wm[raddr_q] : def_word(raddr_q);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
    endtask

    initial begin
        reset = 1'b1;
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);

        // Reset with a live request: everything stays quiet.
        @(negedge clk);
        set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000);
        #1;
        check("rst_gnt0", bus.gnt0, 1'b0);
        check("rst_gnt1", bus.gnt1, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_addr", bus.mem_addr, 10'h000);
        check("rst_rv0", bus.rvalid0, 1'b0);
        check("rst_rv1", bus.rvalid1, 1'b0);

        // Single read from requester 0.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rd_gnt0", bus.gnt0, 1'b1);
        check("rd_gnt1", bus.gnt1, 1'b0);
        check("rd_addr", bus.mem_addr, 10'h005);
        check("rd_we", bus.mem_we, 1'b0);
        @(negedge clk);
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        #1;
        check("rd_rv0", bus.rvalid0, 1'b1);
        check("rd_data0", bus.rdata0, 16'h1234);
        check("rd_rv1", bus.rvalid1, 1'b0);
        check("rd_idle_gnt0", bus.gnt0, 1'b0);
        check("rd_hold_addr", bus.mem_addr, 10'h005);
        check("rd_idle_din", bus.mem_din, 16'h0000);

        // Both requesting, no lock: requester 0 was last, so 1,0,1,0.
        @(negedge clk);
        set0(1'b1, 1'b0, 1'b0, 10'h010, 16'h0000);
        set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0000);
        #1;
        check("rr_a_gnt1", bus.gnt1, 1'b1);
        check("rr_a_gnt0", bus.gnt0, 1'b0);
        check("rr_a_addr", bus.mem_addr, 10'h020);
        check("rr_a_rv0", bus.rvalid0, 1'b0);
        @(negedge clk);
        #1;
        check("rr_b_gnt0", bus.gnt0, 1'b1);
        check("rr_b_addr", bus.mem_addr, 10'h010);
        check("rr_b_rv1", bus.rvalid1, 1'b1);
        check("rr_b_data1", bus.rdata1, 16'hC020);
        @(negedge clk);
        #1;
        check("rr_c_gnt1", bus.gnt1, 1'b1);
        check("rr_c_rv0", bus.rvalid0, 1'b1);
        check("rr_c_data0", bus.rdata0, 16'hC010);
        @(negedge clk);
        #1;
        check("rr_d_gnt0", bus.gnt0, 1'b1);
        check("rr_d_rv1", bus.rvalid1, 1'b1);

        // Write by requester 1 then read back by requester 0.
        @(negedge clk);
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set1(1'b1, 1'b1, 1'b0, 10'h00A, 16'hBEEF);
        #1;
        check("wr_rv0_prev", bus.rvalid0, 1'b1);
        check("wr_data0_prev", bus.rdata0, 16'hC010);
        check("wr_gnt1", bus.gnt1, 1'b1);
        check("wr_we", bus.mem_we, 1'b1);
        check("wr_din", bus.mem_din, 16'hBEEF);
        check("wr_addr", bus.mem_addr, 10'h00A);
        @(negedge clk);
        set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set0(1'b1, 1'b0, 1'b0, 10'h00A, 16'h0000);
        #1;
        check("rb_gnt0", bus.gnt0, 1'b1);
        check("rb_we", bus.mem_we, 1'b0);
        check("rb_no_rv1", bus.rvalid1, 1'b0);
        @(negedge clk);
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        #1;
        check("rb_rv0", bus.rvalid0, 1'b1);
        check("rb_data0", bus.rdata0, 16'hBEEF);

        // Requester 1 alone so requester 0 wins the next contention.
        @(negedge clk);
        set1(1'b1, 1'b0, 1'b0, 10'h030, 16'h0000);
        #1;
        check("pre_gnt1", bus.gnt1, 1'b1);

        // Locked burst by requester 0 against requester 1: 8 holds, a break, then 0 relocks.
        @(negedge clk);
        set0(1'b1, 1'b0, 1'b1, 10'h040, 16'h0000);
        set1(1'b1, 1'b0, 1'b0, 10'h050, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("lk_gnt0_%0d", i), bus.gnt0, (i != 8) ? 1'b1 : 1'b0);
            check($sformatf("lk_gnt1_%0d", i), bus.gnt1, (i == 8) ? 1'b1 : 1'b0);
            @(negedge clk);
        end

        // Reset right after a granted read: its valid must not appear.
        reset = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 10'h040, 16'h0000);
        #1;
        check("rst2_rv0", bus.rvalid0, 1'b0);
        check("rst2_gnt0", bus.gnt0, 1'b0);
        check("rst2_gnt1", bus.gnt1, 1'b0);
        check("rst2_addr", bus.mem_addr, 10'h000);
        check("rst2_din", bus.mem_din, 16'h0000);
        check("rst2_we", bus.mem_we, 1'b0);
        @(negedge clk);
        #1;
        check("rst2b_rv0", bus.rvalid0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_gnt0", bus.gnt0, 1'b1);
        check("post_gnt1", bus.gnt1, 1'b0);
        @(negedge clk);
        #1;
        check("post2_gnt1", bus.gnt1, 1'b1);
        check("post2_rv0", bus.rvalid0, 1'b1);
        check("post2_data0", bus.rdata0, 16'hC040);

        // Uncontended lock by requester 1 never breaks; counter saturates.
        @(negedge clk);
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set1(1'b1, 1'b0, 1'b1, 10'h070, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("sat_gnt1_%0d", i), bus.gnt1, 1'b1);
            @(negedge clk);
        end
        // Saturated lock breaks as soon as requester 0 shows up.
        set0(1'b1, 1'b0, 1'b0, 10'h060, 16'h0000);
        #1;
        check("brk_gnt0", bus.gnt0, 1'b1);
        check("brk_gnt1", bus.gnt1, 1'b0);

        // Idle: no grants, address held at the last granted one.
        @(negedge clk);
        set0(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        set1(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        #1;
        check("idle_gnt0", bus.gnt0, 1'b0);
        check("idle_gnt1", bus.gnt1, 1'b0);
        check("idle_we", bus.mem_we, 1'b0);
        check("idle_addr", bus.mem_addr, 10'h060);
        check("idle_rv0", bus.rvalid0, 1'b1);
        check("idle_data0", bus.rdata0, 16'hC060);
        check("idle_rv1", bus.rvalid1, 1'b0);
        @(negedge clk);
        #1;
        check("idle2_rv0", bus.rvalid0, 1'b0);
        check("idle2_addr", bus.mem_addr, 10'h060);
        check("idle2_din", bus.mem_din, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
